deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/gray_area_package.sv | 37 +++
 rtl/hamming_decode.sv | 78 +++++++
 rtl/deserializer.sv | 119 +++++++++++
 tb/tb_deserializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_area_package.sv
// ---------------------------------------------------------------------------
// gray_area_package
//   Shared types and Hamming code geometry for the serial link.
//   - deser_state_t        : deserializer FSM states.
//   - hamming_code_bits()  : parity bits needed to protect a data word.
//   - hamming_data_pos()   : 1-based codeword position of a data bit.
//   The transmit-side encoder uses the same helpers, so both ends agree on
//   the codeword layout. Data bits fill the non-power-of-two positions in
//   ascending order, and parity bit j sits at position 2**j.
// ---------------------------------------------------------------------------
package gray_area_package;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } deser_state_t;

  // Smallest r such that 2**r >= data_width + r + 1 (single-error correcting).
  function automatic int hamming_code_bits(input int data_width);
    int r = 1;
    while ((1 << r) < data_width + r + 1) r++;
    return r;
  endfunction

  // Position (1-based) in the Hamming codeword of data bit idx.
  function automatic int hamming_data_pos(input int idx);
    int pos  = 2;
    int seen = -1;
    while (seen < idx) begin
      pos++;
      if ((pos & (pos - 1)) != 0) seen++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_decode.sv
// ---------------------------------------------------------------------------
// hamming_decode
//   Single-error-correcting Hamming decoder with one registered stage.
//   The codeword arrives as {data, parity}. It is scattered into Hamming
//   positions, the syndrome is computed, and the bit it points at is flipped.
//   Ports:
//     clk_i, rst_n_i : clock, async active-low reset
//     codeword_i     : {data[DATA_WIDTH-1:0], parity[CODE_BITS-1:0]}
//     valid_i        : codeword_i is valid this cycle
//     data_o         : corrected data, held until the next valid_i
//     corrected_o    : one-cycle pulse with valid_o when a bit was flipped
//     valid_o        : one-cycle pulse, one cycle after valid_i
// ---------------------------------------------------------------------------
module hamming_decode
  import gray_area_package::*;
#(
  parameter  int DATA_WIDTH  = 8,
  localparam int CODE_BITS   = hamming_code_bits(DATA_WIDTH),
  localparam int CODED_WIDTH = DATA_WIDTH + CODE_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [CODED_WIDTH-1:0] codeword_i,
  input  logic                   valid_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   corrected_o,
  output logic                   valid_o
);

  logic [CODED_WIDTH:1]  code;      // codeword in Hamming position order
  logic [CODED_WIDTH:1]  fixed;
  logic [CODE_BITS-1:0]  syndrome;
  logic [DATA_WIDTH-1:0] data_fix;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_data
    assign code[hamming_data_pos(i)] = codeword_i[CODE_BITS + i];
    assign data_fix[i]               = fixed[hamming_data_pos(i)];
  end

  for (genvar j = 0; j < CODE_BITS; j++) begin : g_par
    assign code[1 << j] = codeword_i[j];
  end

  // Syndrome bit j checks every position whose index has bit j set, so a
  // single error produces that position's index.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    syndrome = '0;
    for (int k = 1; k <= CODED_WIDTH; k++) begin
      for (int j = 0; j < CODE_BITS; j++) begin
        if (((k >> j) & 1) == 1) syndrome[j] = syndrome[j] ^ code[k];
      end
    end
  end

  // A syndrome that points at a parity position flips only that parity bit,
  // so the data comes out unchanged but the correction is still flagged.
  always_comb begin
    fixed = code;
    for (int k = 1; k <= CODED_WIDTH; k++) begin
      if (int'(syndrome) == k) fixed[k] = ~code[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o      <= '0;
      corrected_o <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      valid_o     <= valid_i;
      corrected_o <= valid_i && (syndrome != '0);
      if (valid_i) data_o <= data_fix;
    end
  end

endmodule

// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
//   Collects a framed serial bit stream (MSB first) into a parallel word.
//   With HAS_ECC=1 the frame carries Hamming parity after the data, and the
//   word passes through hamming_decode, which adds one cycle of latency.
//   Ports:
//     clk_i, rst_n_i  : clock, async active-low reset
//     serial_in_i     : serial bit, sampled only when enable_i=1
//     enable_i        : serial_in_i carries a valid bit this cycle
//     start_i         : with enable_i, marks the first bit of a frame
//     parallel_out_o  : recovered payload, held until the next frame
//     valid_out_o     : one-cycle pulse, parallel_out_o is valid
//     corrected_o     : pulses with valid_out_o after a single-bit fix
//     frame_err_o     : (DESERIALIZER_FRAME_ERR_EN only) one-cycle pulse
//                       when a restart abandons a partial frame
//   Build option: define DESERIALIZER_FRAME_ERR_EN to add frame_err_o.
// ---------------------------------------------------------------------------
module deserializer
  import gray_area_package::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HAS_ECC    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  serial_in_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] parallel_out_o,
  output logic                  valid_out_o,
  output logic                  corrected_o
`ifdef DESERIALIZER_FRAME_ERR_EN
  ,
  output logic                  frame_err_o
`endif
);

  localparam int CODE_BITS   = hamming_code_bits(DATA_WIDTH);
  localparam int CODED_WIDTH = DATA_WIDTH + CODE_BITS;
  localparam int W           = (HAS_ECC != 0) ? CODED_WIDTH : DATA_WIDTH;
  localparam int CNT_W       = $clog2(W) + 1;

  deser_state_t     state;
  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             start_bit;
  logic             frame_done;

  // A start with a valid bit always begins a frame, from any state.
  assign start_bit  = enable_i && start_i;
  assign frame_done = (state == ST_SHIFT) && enable_i && !start_i &&
                      (cnt == CNT_W'(W - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      // NOTE: the shift register is a small flop array, not a RAM, so it is
      // cleared on reset along with the control state.
      shreg <= '0;
    end else if (start_bit) begin
      // NOTE: non-blocking assignments here let a restart in DECODE overwrite
      // shreg while the decoder still samples the completed codeword.
      state <= ST_SHIFT;
      shreg <= {{(W - 1){1'b0}}, serial_in_i};
      cnt   <= CNT_W'(1);
    end else if (state == ST_SHIFT && enable_i) begin
      shreg <= {shreg[W-2:0], serial_in_i};
      if (frame_done) begin
        cnt <= '0;
        if (HAS_ECC != 0) state <= ST_DECODE;
        else              state <= ST_IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (state == ST_DECODE) begin
      state <= ST_IDLE;
    end
  end

  if (HAS_ECC != 0) begin : g_ecc
    // DECODE lasts one cycle and presents the full codeword to the decoder.
    hamming_decode #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .codeword_i  (shreg),
      .valid_i     (state == ST_DECODE),
      .data_o      (parallel_out_o),
      .corrected_o (corrected_o),
      .valid_o     (valid_out_o)
    );
  end else begin : g_plain
    // The top bit of shreg is shifted out before it is ever needed, because
    // the last bit is taken straight from serial_in_i.
    logic unused_msb;
    assign unused_msb  = shreg[W-1];
    assign corrected_o = 1'b0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        parallel_out_o <= '0;
        valid_out_o    <= 1'b0;
      end else begin
        valid_out_o <= frame_done;
        if (frame_done) parallel_out_o <= {shreg[DATA_WIDTH-2:0], serial_in_i};
      end
    end
  end

`ifdef DESERIALIZER_FRAME_ERR_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) frame_err_o <= 1'b0;
    else          frame_err_o <= start_bit && (state == ST_SHIFT);
  end
`endif

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
//   Drives a plain 8-bit deserializer (dut0) and an ECC one (dut1, 12-bit
//   frames). Expected words and their arrival cycles go into a queue per DUT
//   when the last bit is driven. Negedge monitors pop and compare on every
//   valid_out_o pulse.
// ---------------------------------------------------------------------------
module tb_deserializer;

  typedef struct {
    logic [7:0] data;
    logic       corr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0, en0, st0, s1, en1, st1;
  logic [7:0] out0, out1;
  logic       vld0, vld1, cor0, cor1;
`ifdef DESERIALIZER_FRAME_ERR_EN
  logic       ferr0, ferr1;
  int         ferr0_q[$];
  int         ferr1_cnt = 0;
  int         restart_cyc;
`endif

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  deserializer #(.DATA_WIDTH(8), .HAS_ECC(0)) dut0 (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .serial_in_i    (s0),
    .enable_i       (en0),
    .start_i        (st0),
    .parallel_out_o (out0),
    .valid_out_o    (vld0),
    .corrected_o    (cor0)
`ifdef DESERIALIZER_FRAME_ERR_EN
    ,
    .frame_err_o    (ferr0)
`endif
  );

  deserializer #(.DATA_WIDTH(8), .HAS_ECC(1)) dut1 (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .serial_in_i    (s1),
    .enable_i       (en1),
    .start_i        (st1),
    .parallel_out_o (out1),
    .valid_out_o    (vld1),
    .corrected_o    (cor1)
`ifdef DESERIALIZER_FRAME_ERR_EN
    ,
    .frame_err_o    (ferr1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent Hamming(12,8) encoder: data bits at positions 3,5,6,7,9..12.
  function automatic logic [11:0] encode(input logic [7:0] d);
    int         pos [8];
    logic [3:0] p;
    pos = '{3, 5, 6, 7, 9, 10, 11, 12};
    p   = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++)
        if (((pos[i] >> j) & 1) == 1) p[j] = p[j] ^ d[i];
    return {d, p};
  endfunction

  task automatic drive0(input logic en, input logic st, input logic b);
    en0 = en; st0 = st; s0 = b;
    @(posedge clk); #1;
    en0 = 1'b0; st0 = 1'b0; s0 = 1'b0;
  endtask

  task automatic drive1(input logic en, input logic st, input logic b);
    en1 = en; st1 = st; s1 = b;
    @(posedge clk); #1;
    en1 = 1'b0; st1 = 1'b0; s1 = 1'b0;
  endtask

  // Gap of gap_len cycles (enable low, start = gap_start) after bit gap_at.
  task automatic send_frame0(input logic [7:0] d, input int gap_at,
                             input int gap_len, input logic gap_start);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      drive0(1'b1, i == 7, d[i]);
      if (8 - i == gap_at) repeat (gap_len) drive0(1'b0, gap_start, 1'b1);
    end
    e.data = d; e.corr = 1'b0; e.cyc = cyc;
    q0.push_back(e);
  endtask

  task automatic send_code1(input logic [11:0] f, input logic [7:0] d, input logic c);
    exp_t e;
    for (int i = 11; i >= 0; i--) drive1(1'b1, i == 11, f[i]);
    e.data = d; e.corr = c; e.cyc = cyc + 1;
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (vld0 === 1'b1) begin
      check("dut0_valid_expected", q0.size() > 0, 1'b1);
      if (q0.size() > 0) begin
        m0 = q0.pop_front();
        check("dut0_data", out0, m0.data);
        check("dut0_corrected", cor0, m0.corr);
        check("dut0_valid_cycle", cyc, m0.cyc);
      end
    end
    if (vld1 === 1'b1) begin
      check("dut1_valid_expected", q1.size() > 0, 1'b1);
      if (q1.size() > 0) begin
        m1 = q1.pop_front();
        check("dut1_data", out1, m1.data);
        check("dut1_corrected", cor1, m1.corr);
        check("dut1_valid_cycle", cyc, m1.cyc);
      end
    end
`ifdef DESERIALIZER_FRAME_ERR_EN
    if (ferr0 === 1'b1) ferr0_q.push_back(cyc);
    if (ferr1 === 1'b1) ferr1_cnt++;
`endif
  end

  initial begin
    rst_n = 1'b0;
    s0 = 1'b0; en0 = 1'b0; st0 = 1'b0;
    s1 = 1'b0; en1 = 1'b0; st1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out0", out0, 8'h00);
    check("reset_valid0", vld0, 1'b0);
    check("reset_corr0", cor0, 1'b0);
    check("reset_out1", out1, 8'h00);
    check("reset_valid1", vld1, 1'b0);
    check("reset_corr1", cor1, 1'b0);
`ifdef DESERIALIZER_FRAME_ERR_EN
    check("reset_ferr0", ferr0, 1'b0);
`endif
    rst_n = 1'b1;
    drive0(1'b0, 1'b0, 1'b0);

    // Start without enable, then enabled bits without start: all ignored.
    drive0(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive0(1'b1, 1'b0, 1'b1);
    drive0(1'b0, 1'b0, 1'b0);

    // Contiguous 0xA5, then the output must hold while idle.
    send_frame0(8'hA5, 0, 0, 1'b0);
    repeat (3) drive0(1'b0, 1'b0, 1'b0);
    check("hold_out0", out0, 8'hA5);
    check("hold_valid0_low", vld0, 1'b0);

    // Back-to-back frames, no idle cycle between them.
    send_frame0(8'h3C, 0, 0, 1'b0);
    send_frame0(8'hC3, 0, 0, 1'b0);
    repeat (2) drive0(1'b0, 1'b0, 1'b0);

    // Three bits of a frame, then a restart with 0x5A.
    drive0(1'b1, 1'b1, 1'b1);
    drive0(1'b1, 1'b0, 1'b1);
    drive0(1'b1, 1'b0, 1'b1);
`ifdef DESERIALIZER_FRAME_ERR_EN
    restart_cyc = cyc + 1;
`endif
    send_frame0(8'h5A, 0, 0, 1'b0);
    repeat (2) drive0(1'b0, 1'b0, 1'b0);

    // 0xA5 with a two-cycle enable gap after bit 4. Start is high during the
    // gap but enable is low, so it must not restart the frame.
    send_frame0(8'hA5, 4, 2, 1'b1);
    repeat (2) drive0(1'b0, 1'b0, 1'b0);

    // Reset after 4 bits, then the rest of that frame without a start.
    drive0(1'b1, 1'b1, 1'b1);
    drive0(1'b1, 1'b0, 1'b0);
    drive0(1'b1, 1'b0, 1'b0);
    drive0(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out0", out0, 8'h00);
    check("midreset_valid0", vld0, 1'b0);
    check("midreset_corr0", cor0, 1'b0);
    drive0(1'b1, 1'b0, 1'b1);
    check("inreset_out0", out0, 8'h00);
    rst_n = 1'b1;
    repeat (4) drive0(1'b1, 1'b0, 1'b1);
    send_frame0(8'h81, 0, 0, 1'b0);
    repeat (2) drive0(1'b0, 1'b0, 1'b0);

    // ECC: clean word, single data error, back-to-back parity error, MSB error.
    send_code1(encode(8'h3C), 8'h3C, 1'b0);
    repeat (3) drive1(1'b0, 1'b0, 1'b0);
    send_code1(encode(8'hA5) ^ 12'h080, 8'hA5, 1'b1);
    send_code1(encode(8'h5A) ^ 12'h002, 8'h5A, 1'b1);
    repeat (3) drive1(1'b0, 1'b0, 1'b0);
    check("ecc_hold_out1", out1, 8'h5A);
    check("ecc_corr1_pulse_only", cor1, 1'b0);
    send_code1(encode(8'hFF) ^ 12'h800, 8'hFF, 1'b1);
    repeat (4) drive1(1'b0, 1'b0, 1'b0);

    check("dut0_all_outputs_seen", q0.size(), 0);
    check("dut1_all_outputs_seen", q1.size(), 0);
`ifdef DESERIALIZER_FRAME_ERR_EN
    check("ferr0_pulse_count", ferr0_q.size(), 1);
    if (ferr0_q.size() > 0) check("ferr0_pulse_cycle", ferr0_q[0], restart_cyc);
    check("ferr1_pulse_count", ferr1_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
